sram_controller: RTL and testbench

Memory-access engine for the MEM stage. It consumes the EXE stage's ALU result (as the address) and the forwarded Rm value (as store data), and performs 32-bit loads and stores against an external 16-bit asynchronous SRAM as two half-word transfers. While an access is in flight it deasserts `ready`, and the pipeline uses that to freeze all upstream stages. Read data is presented to MEM/WB when `ready` returns high.

---
 rtl/sram_controller.sv | 177 +++++++++++++++++
 tb/tb_sram_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// MEM-stage access engine: 32-bit loads/stores as two half-word transfers
// on an external asynchronous 16-bit SRAM, freezing the pipeline via ready.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LO   = 3'd1,
        S_HI   = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [16:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [17:0] addr_q, addr_d;
    logic        we_n_q, we_n_d;
    logic        dq_oe_q, dq_oe_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic [31:0] off_s;
    logic        req_s;

    // Addresses below BASE_ADDR wrap into the top of the SRAM by design.
    assign off_s = address - BASE_ADDR;
    assign req_s = wr_en | rd_en;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            is_wr_q  <= 1'b0;
            word_q   <= 17'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            addr_q   <= 18'd0;
            we_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            dq_out_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            word_q   <= word_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            we_n_q   <= we_n_d;
            dq_oe_q  <= dq_oe_d;
            dq_out_q <= dq_out_d;
        end
    end

    // Next-state, request latching and load-data capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    state_d = S_LO;
                    is_wr_d = wr_en;
                    word_d  = off_s[18:2];
                    wdata_d = writeData;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LO: begin
                state_d = S_HI;
                if (!is_wr_q) begin
                    rdata_d[15:0] = SRAM_DQ;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            S_HI: begin
                cnt_d = 4'd0;
                if (WAIT_CYCLES > 0) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_DONE;
                end
                if (!is_wr_q) begin
                    rdata_d[31:16] = SRAM_DQ;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus controls are registered from the upcoming state so they are glitch-free.
    always_comb begin
        addr_d   = 18'd0;
        we_n_d   = 1'b1;
        dq_oe_d  = 1'b0;
        dq_out_d = 16'd0;
        case (state_d)
            S_LO: begin
                addr_d = {word_d, 1'b0};
                if (is_wr_d) begin
                    we_n_d   = 1'b0;
                    dq_oe_d  = 1'b1;
                    dq_out_d = wdata_d[15:0];
                end else begin
                    we_n_d = 1'b1;
                end
            end
            S_HI: begin
                addr_d = {word_d, 1'b1};
                if (is_wr_d) begin
                    we_n_d   = 1'b0;
                    dq_oe_d  = 1'b1;
                    dq_out_d = wdata_d[31:16];
                end else begin
                    we_n_d = 1'b1;
                end
            end
            default: begin
                addr_d = 18'd0;
            end
        endcase
    end

    assign ready     = ~req_s | (state_q == S_DONE);
    assign readData  = rdata_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: default build plus a WAIT_CYCLES=0
// build sharing the request inputs, each with its own SRAM model.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, writeData;
    logic [31:0] readData, readData0;
    logic        ready, ready0;
    wire  [15:0] SRAM_DQ, SRAM_DQ0;
    logic [17:0] SRAM_ADDR, SRAM_ADDR0;
    logic        SRAM_WE_N, SRAM_WE_N0;
    logic        ub_n, lb_n, ce_n, oe_n;
    logic        ub_n0, lb_n0, ce_n0, oe_n0;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [15:0] mem  [0:63];
    logic [15:0] mem0 [0:63];
    logic [15:0] tmem [0:63];
    logic [31:0] ref_rd;

    sram_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(writeData),
        .readData(readData), .ready(ready),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    sram_controller #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .writeData(writeData),
        .readData(readData0), .ready(ready0),
        .SRAM_DQ(SRAM_DQ0), .SRAM_ADDR(SRAM_ADDR0), .SRAM_WE_N(SRAM_WE_N0),
        .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0), .SRAM_CE_N(ce_n0), .SRAM_OE_N(oe_n0)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM models: drive on read, write on clock edges with WE_N low.
    assign SRAM_DQ  = (SRAM_WE_N  && !oe_n ) ? mem [SRAM_ADDR[5:0]]  : 16'hzzzz;
    assign SRAM_DQ0 = (SRAM_WE_N0 && !oe_n0) ? mem0[SRAM_ADDR0[5:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_WE_N)  mem [SRAM_ADDR[5:0]]  <= SRAM_DQ;
        if (!SRAM_WE_N0) mem0[SRAM_ADDR0[5:0]] <= SRAM_DQ0;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'(off[18:2]);
    endfunction

    // One access starting at the current cycle (cycle 0); returns one cycle after DONE.
    task automatic access(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_mask, input bit chk0);
        int          lat, lat0, wi;
        logic [31:0] mask, rd0_seen;
        wr_en = w; rd_en = r; address = a; writeData = d;
        wi = word_of(a) * 2;
        if (w) begin
            tmem[wi]     = d[15:0];
            tmem[wi + 1] = d[31:16];
        end else begin
            ref_rd = {tmem[wi + 1], tmem[wi]};
        end
        exp_q.push_back(ref_rd);
        lat = -1; lat0 = -1; mask = 32'd0; rd0_seen = 32'd0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (!SRAM_WE_N) mask[c] = 1'b1;
            if (lat0 < 0 && ready0) begin
                lat0 = c;
                rd0_seen = readData0;
            end
            if (ready) begin
                lat = c;
                break;
            end
        end
        check_eq("ready_latency", lat, 32'd5);
        check_eq("we_n_window", mask, exp_mask);
        check_eq("readData", readData, exp_q.pop_front());
        if (chk0) begin
            check_eq("w0_ready_latency", lat0, 32'd3);
            check_eq("w0_readData", rd0_seen, ref_rd);
        end
        @(posedge clk); #1;
    endtask

    task automatic go_idle(input int n);
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'd0; mem0[i] = 16'd0; tmem[i] = 16'd0;
        end
        ref_rd = 32'd0;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; writeData = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_readData", readData, 32'd0);
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check_eq("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        check_eq("tied_lows", {28'd0, ub_n, lb_n, ce_n, oe_n}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        access(1'b1, 1'b0, 32'd1024, 32'h12345678, 32'b110, 1'b0);
        check_eq("store_sram0", {16'd0, mem[0]}, 32'h5678);
        check_eq("store_sram1", {16'd0, mem[1]}, 32'h1234);
        go_idle(4);
        access(1'b0, 1'b1, 32'd1024, 32'd0, 32'd0, 1'b1);
        check_eq("load_value", readData, 32'h12345678);
        go_idle(4);

        access(1'b1, 1'b0, 32'd1034, 32'hDEADBEEF, 32'b110, 1'b0);
        check_eq("map_sram4", {16'd0, mem[4]}, 32'hBEEF);
        check_eq("map_sram5", {16'd0, mem[5]}, 32'hDEAD);
        go_idle(2);
        access(1'b0, 1'b1, 32'd1032, 32'd0, 32'd0, 1'b0);
        check_eq("map_load", readData, 32'hDEADBEEF);
        go_idle(2);

        // Both requests set, then a load issued right at the DONE edge.
        access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 32'b110, 1'b0);
        check_eq("conflict_sram8", {16'd0, mem[8]}, 32'hF00D);
        check_eq("conflict_sram9", {16'd0, mem[9]}, 32'hCAFE);
        access(1'b0, 1'b1, 32'd1040, 32'd0, 32'd0, 1'b0);
        check_eq("b2b_load", readData, 32'hCAFEF00D);
        go_idle(2);

        // Reset asserted during HI of a load.
        wr_en = 1'b0; rd_en = 1'b1; address = 32'd1032;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_hi_addr", {14'd0, SRAM_ADDR}, 32'd5);
        rst = 1'b0;
        #1;
        check_eq("midrst_readData", readData, 32'd0);
        check_eq("midrst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        check_eq("midrst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        check_eq("midrst_dq_model", {16'd0, SRAM_DQ}, 32'h5678);
        check_eq("midrst_ready_req", {31'd0, ready}, 32'd0);
        rd_en = 1'b0;
        #1;
        check_eq("midrst_ready_idle", {31'd0, ready}, 32'd1);
        ref_rd = 32'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_ready", {31'd0, ready}, 32'd1);
        @(posedge clk); #1;

        access(1'b0, 1'b1, 32'd1032, 32'd0, 32'd0, 1'b0);
        check_eq("post_rst_load", readData, 32'hDEADBEEF);
        go_idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
